// File: rtl/spike_event_packetizer.sv
// spike_event_packetizer: timestamps spike pulses against an ADC sample counter
// and queues the records in a registered-output first-word-fall-through FIFO.
// Optional feature macro SPIKE_PKT_ISI_EN: records inter-spike intervals
// instead of absolute timestamps.
module spike_event_packetizer #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned TS_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_en,
    input  logic                         spike_in,
    output logic [TS_WIDTH-1:0]          evt_data,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [$clog2(DEPTH):0]       fifo_level,
    output logic                         overflow,
    output logic [7:0]                   drop_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [TS_WIDTH-1:0] mem [DEPTH];
    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] rec;
    logic [TS_WIDTH-1:0] data_nxt;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       rd_ptr_nxt;
    logic [LW-1:0]       level_nxt;
    logic [LW-1:0]       remain;
    logic                pop;
    logic                push;
    logic                full;

    assign pop  = evt_valid & evt_ready;
    assign full = (fifo_level == LW'(DEPTH));
    // A full FIFO still takes a spike when the head leaves in the same cycle.
    assign push = spike_in & (~full | pop);

`ifdef SPIKE_PKT_ISI_EN
    logic [TS_WIDTH-1:0] last_ts;

    assign rec = ts - last_ts;

    // Reference point for the interval moves on every spike, kept or dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_ts <= '0;
        end else if (spike_in) begin
            last_ts <= ts;
        end
    end
`else
    assign rec = ts;
`endif

    // Next occupancy, read pointer and head record.
    always_comb begin
        level_nxt  = fifo_level;
        rd_ptr_nxt = rd_ptr;
        data_nxt   = evt_data;
        remain     = fifo_level - LW'(pop);
        if (pop) begin
            rd_ptr_nxt = rd_ptr + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_nxt = fifo_level + LW'(1);
            2'b01:   level_nxt = fifo_level - LW'(1);
            default: level_nxt = fifo_level;
        endcase
        // New head is the incoming record only when nothing older survives.
        if (level_nxt != '0) begin
            if (remain == '0) begin
                data_nxt = rec;
            end else begin
                data_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    // Record storage; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= rec;
        end
    end

    // Counter, pointers, registered outputs and drop accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts         <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            evt_valid  <= 1'b0;
            evt_data   <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (sample_en) begin
                ts <= ts + TS_WIDTH'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr     <= rd_ptr_nxt;
            fifo_level <= level_nxt;
            evt_valid  <= (level_nxt != '0);
            evt_data   <= data_nxt;
            if (spike_in && !push) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spike_event_packetizer.sv
// Bench for spike_event_packetizer: constant-expectation vector table, directed
// corner sequences and a randomized phase checked against a queue-based model.
module tb_spike_event_packetizer;

    localparam int DEPTH = 8;
`ifdef SPIKE_PKT_ISI_EN
    localparam bit ISI = 1'b1;
`else
    localparam bit ISI = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_en = 1'b0;
    logic        spike_in = 1'b0;
    logic        evt_ready = 1'b0;
    logic [15:0] evt_data;
    logic        evt_valid;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] q[$];
    logic [15:0] m_ts = '0;
    logic [15:0] m_last = '0;
    bit          m_ovf = 1'b0;
    int          m_drop = 0;

    typedef struct {
        bit          r, se, sp, rd;
        bit          v;
        logic [15:0] d;
        int          l;
        bit          o;
        int          dc;
    } vec_t;
    vec_t vecs[$];

    spike_event_packetizer #(.DEPTH(8), .TS_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .spike_in(spike_in),
        .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .fifo_level(fifo_level), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void add(bit r, bit se, bit sp, bit rd, bit v,
                                logic [15:0] d, int l, bit o, int dc);
        vec_t x;
        x.r = r; x.se = se; x.sp = sp; x.rd = rd;
        x.v = v; x.d = d; x.l = l; x.o = o; x.dc = dc;
        vecs.push_back(x);
    endfunction

    // One clock: apply inputs, advance the model, compare all outputs.
    task automatic cyc(input bit r, input bit se, input bit sp, input bit rd);
        bit          pop;
        bit          acc;
        logic [15:0] rec;
        rst = r; sample_en = se; spike_in = sp; evt_ready = rd;
        @(posedge clk);
        if (r) begin
            q.delete();
            m_ts = '0; m_last = '0; m_ovf = 1'b0; m_drop = 0;
        end else begin
            pop = (q.size() != 0) && rd;
            acc = sp && ((q.size() < DEPTH) || pop);
            rec = ISI ? 16'(m_ts - m_last) : m_ts;
            if (sp) m_last = m_ts;
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(rec);
            if (sp && !acc) begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
            if (se) m_ts = m_ts + 16'd1;
        end
        #1;
        check("model_valid", 32'(evt_valid), 32'(q.size() != 0));
        check("model_level", 32'(fifo_level), 32'(q.size()));
        check("model_overflow", 32'(overflow), 32'(m_ovf));
        check("model_drop", 32'(drop_count), 32'(m_drop));
        if (q.size() != 0) check("model_data", 32'(evt_data), 32'(q[0]));
    endtask

    initial begin
        logic [15:0] last_seen;

        // Reset then 5 samples and a spike; spike lands one cycle later with ts=5.
        add(1, 0, 0, 0, 0, 16'd0, 0, 0, 0);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 16'd0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 16'd5, 1, 0, 0);
        add(0, 0, 0, 1, 0, 16'd0, 0, 0, 0);
        // Ten spikes at ts 0..9 with no consumer: 8 kept, 2 dropped.
        add(1, 0, 0, 0, 0, 16'd0, 0, 0, 0);
        for (int i = 0; i < 10; i++)
            add(0, 1, 1, 0, 1, 16'd0, (i < 8) ? i + 1 : 8, i >= 8, (i >= 8) ? i - 7 : 0);
        // Drain in order, one record per cycle.
        for (int j = 1; j <= 8; j++)
            add(0, 0, 0, 1, j < 8, ISI ? 16'd1 : 16'(j), 8 - j, 1, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].r, vecs[i].se, vecs[i].sp, vecs[i].rd);
            check("vec_valid", 32'(evt_valid), 32'(vecs[i].v));
            check("vec_level", 32'(fifo_level), 32'(vecs[i].l));
            check("vec_overflow", 32'(overflow), 32'(vecs[i].o));
            check("vec_drop", 32'(drop_count), 32'(vecs[i].dc));
            if (vecs[i].r) check("vec_reset_data", 32'(evt_data), 32'd0);
            else if (vecs[i].v) check("vec_data", 32'(evt_data), 32'(vecs[i].d));
        end

        // Full FIFO with spike and pop together: no drop, new record goes last.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, 1, 0);
        cyc(0, 0, 1, 1);
        check("full_swap_level", 32'(fifo_level), 32'd8);
        check("full_swap_drop", 32'(drop_count), 32'd0);
        check("full_swap_ovf", 32'(overflow), 32'd0);
        check("full_swap_head", 32'(evt_data), ISI ? 32'd1 : 32'd1);
        last_seen = '0;
        for (int j = 0; j < 8; j++) begin
            last_seen = evt_data;
            cyc(0, 0, 0, 1);
        end
        check("full_swap_last", 32'(last_seen), ISI ? 32'd1 : 32'd8);
        check("full_swap_empty", 32'(evt_valid), 32'd0);

        // Timestamp wrap: record at 0xFFFF, then counter reads 0.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 65535; i++) begin
            rst = 1'b0; sample_en = 1'b1; spike_in = 1'b0; evt_ready = 1'b0;
            @(posedge clk);
            m_ts = m_ts + 16'd1;
        end
        #1;
        cyc(0, 1, 1, 0);
        check("wrap_rec", 32'(evt_data), 32'hFFFF);
        cyc(0, 0, 1, 1);
        check("wrap_next", 32'(evt_data), ISI ? 32'd1 : 32'd0);
        cyc(0, 0, 0, 1);

        // Spikes at ts 100, 350, 360.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 100; i++) cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 250; i++) cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        check("ts_rec0", 32'(evt_data), 32'd100);
        cyc(0, 0, 0, 1);
        check("ts_rec1", 32'(evt_data), ISI ? 32'd250 : 32'd350);
        cyc(0, 0, 0, 1);
        check("ts_rec2", 32'(evt_data), ISI ? 32'd10 : 32'd360);
        cyc(0, 0, 0, 1);

        // Reset with level 3 and overflow set; inputs during reset are ignored.
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) cyc(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1);
        check("pre_rst_level", 32'(fifo_level), 32'd3);
        check("pre_rst_ovf", 32'(overflow), 32'd1);
        cyc(1, 1, 1, 1);
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_data", 32'(evt_data), 32'd0);
        cyc(0, 0, 1, 0);
        check("post_rst_ts", 32'(evt_data), 32'd0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 399) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 3) != 0 ? (i % 600 < 300) : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spike_event_packetizer.md
SPIKE_EVENT_PACKETIZER -- requirements
Module: spike_event_packetizer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, event FIFO depth; power of two, 2..64.
REQ-002 SHALL have parameter TS_WIDTH, default 16, timestamp/record width in bits.
REQ-003 SHALL have port clk, input, 1, sole clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port sample_en, input, 1, one-cycle strobe per ADC sample (2 kHz rate).
REQ-006 SHALL have port spike_in, input, 1, one-cycle spike pulse from the upstream detector.
REQ-007 SHALL have port evt_data, output, TS_WIDTH, record at FIFO head.
REQ-008 SHALL have port evt_valid, output, 1, FIFO non-empty.
REQ-009 SHALL have port evt_ready, input, 1, consumer accepts the head record.
REQ-010 SHALL have port fifo_level, output, log2(DEPTH)+1, current occupancy.
REQ-011 SHALL have port overflow, output, 1, sticky flag for dropped events.
REQ-012 SHALL have port drop_count, output, 8, number of dropped events, saturating.

Function
REQ-013 SHALL keep a TS_WIDTH sample counter ts that increments by 1 on each cycle with sample_en=1 and wraps from all-ones to 0.
REQ-014 SHALL push one record on each cycle with spike_in=1; the record uses ts as it is before that cycle's increment.
REQ-015 SHALL be a first-word-fall-through FIFO: evt_valid=(level!=0), evt_data=head record, both driven from registers.
REQ-016 SHALL pop on cycles with evt_valid=1 and evt_ready=1; the next record, if any, appears on the following cycle.
REQ-017 SHALL hold evt_data stable while evt_valid=1 and evt_ready=0.
REQ-018 SHALL not bypass: a push into an empty FIFO gives evt_valid=1 one cycle after the spike_in cycle.
REQ-019 SHALL accept a push when level<DEPTH, or when level=DEPTH and a pop occurs in the same cycle; level is then unchanged.
REQ-020 SHALL, when a push is refused, discard the record, set overflow=1 and increment drop_count, which saturates at 255.
REQ-021 SHALL, on a simultaneous push and pop at level 1..DEPTH-1, leave level unchanged and keep order.
REQ-022 SHALL ignore evt_ready while evt_valid=0.
REQ-023 SHALL update fifo_level in the cycle after each push or pop.
REQ-024 SHALL clear overflow and drop_count only by reset.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, set ts=0, level=0, read/write pointers=0, evt_valid=0, evt_data=0, fifo_level=0, overflow=0, drop_count=0 and last_ts=0.
REQ-026 SHALL ignore spike_in and sample_en in reset cycles; records queued before reset are lost.

Configuration
REQ-027 SHALL support macro SPIKE_PKT_ISI_EN.
REQ-028 SHALL, with SPIKE_PKT_ISI_EN defined, record the inter-spike interval (ts - last_ts) mod 2^TS_WIDTH and update last_ts to ts on every spike_in, dropped or accepted; the first spike after reset records ts - 0.
REQ-029 SHALL, without SPIKE_PKT_ISI_EN, record absolute ts and build no last_ts register.

Verification
REQ-030 SHALL cover: after reset, 5 sample_en pulses then spike_in -> evt_valid=1 on the next cycle, evt_data=5, fifo_level=1.
REQ-031 SHALL cover: evt_ready=0 and 10 spikes at ts=0..9 -> level=8, records 0..7 held, overflow=1, drop_count=2; then evt_ready=1 -> 0..7 drain in order over 8 cycles.
REQ-032 SHALL cover: FIFO full, spike_in and pop in the same cycle -> no drop, level stays 8, new record last.
REQ-033 SHALL cover: ts=0xFFFF, sample_en and spike_in together -> record 0xFFFF, ts becomes 0; the next spike records 0x0000.
REQ-034 SHALL cover: SPIKE_PKT_ISI_EN defined, spikes at ts=100, 350, 360 -> records 100, 250, 10.
REQ-035 SHALL cover: rst asserted with level=3 and overflow=1 -> next cycle evt_valid=0, fifo_level=0, overflow=0, drop_count=0.
